ascon_aead_core: RTL

//  Parametrised ASCON-128 AEAD engine, one permutation round per cycle, supporting encrypt and decrypt.

---
 rtl/ascon_aead_core.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ascon_aead_core.sv
// ascon_aead_core: ASCON-128 AEAD engine, one permutation round per clock, encrypt and decrypt
module ascon_aead_core #(
    parameter int          NB_AD   = 1,
    parameter int          NB_DATA = 4,
    parameter logic [63:0] IV      = 64'h80400C0600000000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] tag_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [63:0]  in_data_i,
    output logic         out_valid_o,
    output logic [63:0]  data_o,
    output logic         tag_valid_o,
    output logic [127:0] tag_o,
    output logic         tag_match_o,
    output logic         busy_o,
    output logic         end_o
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INIT      = 3'd1;
    localparam logic [2:0] WAIT_AD   = 3'd2;
    localparam logic [2:0] PERM_AD   = 3'd3;
    localparam logic [2:0] WAIT_DATA = 3'd4;
    localparam logic [2:0] PERM_DATA = 3'd5;
    localparam logic [2:0] FINAL     = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;
    localparam int   NB_MAX  = NB_AD > NB_DATA ? NB_AD : NB_DATA;
    localparam int   BW      = $clog2(NB_MAX + 1);
    localparam logic AD_SKIP = (NB_AD == 0);
    // 5-bit S-box, entry 31 first; index bit 4 is the S0 column bit
    localparam logic [159:0] SBOX = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
    };

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] round_f(input logic [319:0] st, input logic [3:0] r);
        logic [63:0] a [5];
        logic [63:0] b [5];
        logic [4:0]  col;
        for (int w = 0; w < 5; w++) a[w] = st[319 - 64 * w -: 64];
        a[2] = a[2] ^ {56'd0, 4'hF - r, r};
        for (int i = 0; i < 64; i++) begin
            col = SBOX[5 * int'({a[0][i], a[1][i], a[2][i], a[3][i], a[4][i]}) +: 5];
            {b[0][i], b[1][i], b[2][i], b[3][i], b[4][i]} = col;
        end
        return {b[0] ^ ror(b[0], 19) ^ ror(b[0], 28),
                b[1] ^ ror(b[1], 61) ^ ror(b[1], 39),
                b[2] ^ ror(b[2], 1)  ^ ror(b[2], 6),
                b[3] ^ ror(b[3], 10) ^ ror(b[3], 17),
                b[4] ^ ror(b[4], 7)  ^ ror(b[4], 41)};
    endfunction

    logic [2:0]    state;
    logic [319:0]  s;
    logic [3:0]    rnd;
    logic [BW-1:0] blk;
    logic          mode;
    logic [319:0]  s_rnd;
    logic [319:0]  post;
    logic [127:0]  tag_next;
    logic [63:0]   s0;
    logic [2:0]    nxt;
    logic          last_rnd;
    logic          ad_done;
    logic          last_blk;

    always_comb begin
        s_rnd    = round_f(s, rnd);
        s0       = s[319:256];
        last_rnd = rnd == 4'd11;
        ad_done  = blk == BW'(NB_AD);
        last_blk = blk == BW'(NB_DATA - 1);
        tag_next = s_rnd[127:0] ^ key_i;
        post     = state == INIT ? {192'd0, key_i ^ {127'd0, AD_SKIP}} :
                   (state == PERM_AD && ad_done) ? 320'd1 : 320'd0;
        nxt      = state == INIT ? (AD_SKIP ? WAIT_DATA : WAIT_AD) :
                   state == PERM_AD ? (ad_done ? WAIT_DATA : WAIT_AD) :
                   state == PERM_DATA ? WAIT_DATA : DONE;
    end

    assign in_ready_o  = state == WAIT_AD || state == WAIT_DATA;
    assign busy_o      = state != IDLE;
    assign tag_valid_o = state == DONE;
    assign end_o       = state == DONE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            s           <= '0;
            rnd         <= '0;
            blk         <= '0;
            mode        <= 1'b0;
            out_valid_o <= 1'b0;
            data_o      <= '0;
            tag_o       <= '0;
            tag_match_o <= 1'b0;
        end else begin
            out_valid_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    s           <= {IV, key_i, nonce_i};
                    mode        <= mode_i;
                    rnd         <= '0;
                    blk         <= '0;
                    tag_match_o <= 1'b0;
                    state       <= INIT;
                end
                WAIT_AD: if (in_valid_i) begin
                    s[319:256] <= s0 ^ in_data_i;
                    blk        <= blk + BW'(1);
                    rnd        <= 4'd6;
                    state      <= PERM_AD;
                end
                WAIT_DATA: if (in_valid_i) begin
                    data_o      <= s0 ^ in_data_i;
                    out_valid_o <= 1'b1;
                    s[319:256]  <= mode ? in_data_i : s0 ^ in_data_i;
                    blk         <= blk + BW'(1);
                    if (last_blk) begin
                        s[255:128] <= s[255:128] ^ key_i;
                        rnd        <= 4'd0;
                        state      <= FINAL;
                    end else begin
                        rnd   <= 4'd6;
                        state <= PERM_DATA;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    // INIT, PERM_AD, PERM_DATA and FINAL all run one round per cycle
                    s   <= last_rnd ? s_rnd ^ post : s_rnd;
                    rnd <= rnd + 4'd1;
                    if (last_rnd) begin
                        state <= nxt;
                        if (state == PERM_AD && ad_done) blk <= '0;
                        if (state == FINAL) begin
                            tag_o       <= tag_next;
                            tag_match_o <= mode && tag_next == tag_i;
                            blk         <= '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule
